// File: rtl/usb_txn_ctrl_if.sv
// rtl/usb_txn_ctrl_if.sv - request, pipeOut and pipeIn signal bundle for usb_txn_ctrl
interface usb_txn_ctrl_if;
    logic        start;
    logic        is_in;
    logic [6:0]  txn_addr;
    logic [3:0]  txn_endp;
    logic [63:0] wdata;
    logic        busy;
    logic        done;
    logic        success;
    logic [63:0] rdata;
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data;
    logic        pkttype;
    logic        pktready_bs;
    logic        tx_sent;
    logic        writing;
    logic        rx_pktready;
    logic [63:0] rx_data;
    logic        rx_error;
    logic        rx_ack;
    logic        rx_nak;

    modport master (
        output start, is_in, txn_addr, txn_endp, wdata,
        output tx_sent, rx_pktready, rx_data, rx_error, rx_ack, rx_nak,
        input  busy, done, success, rdata, pid, addr, endp, data,
        input  pkttype, pktready_bs, writing
    );

    modport slave (
        input  start, is_in, txn_addr, txn_endp, wdata,
        input  tx_sent, rx_pktready, rx_data, rx_error, rx_ack, rx_nak,
        output busy, done, success, rdata, pid, addr, endp, data,
        output pkttype, pktready_bs, writing
    );
endinterface

// File: rtl/usb_txn_ctrl.sv
// rtl/usb_txn_ctrl.sv - host USB transaction sequencer with NAK/error/timeout retry
module usb_txn_ctrl #(
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 8
) (
    input  logic          clk,
    input  logic          rst_L,
    usb_txn_ctrl_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_TOK   = 4'd1;
    localparam logic [3:0] S_TOKW  = 4'd2;
    localparam logic [3:0] S_DAT   = 4'd3;
    localparam logic [3:0] S_DATW  = 4'd4;
    localparam logic [3:0] S_HSW   = 4'd5;
    localparam logic [3:0] S_INW   = 4'd6;
    localparam logic [3:0] S_ACK   = 4'd7;
    localparam logic [3:0] S_ACKW  = 4'd8;
    localparam logic [3:0] S_RETRY = 4'd9;
    localparam logic [3:0] S_FIN   = 4'd10;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_ACK   = 4'b0010;

    logic [3:0]    state_q, state_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          is_in_q, is_in_d;
    logic [6:0]    addr_q, addr_d;
    logic [3:0]    endp_q, endp_d;
    logic [63:0]   wdata_q, wdata_d;
    logic          success_q, success_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [3:0]    pid_q, pid_d;
    logic [63:0]   data_q, data_d;
    logic          pkttype_q, pkttype_d;
    logic          pktready_q, pktready_d;
    logic          writing_q, writing_d;

    logic tmo_hit;
    assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        tmo_d     = tmo_q;
        is_in_d   = is_in_q;
        addr_d    = addr_q;
        endp_d    = endp_q;
        wdata_d   = wdata_q;
        success_d = success_q;
        rdata_d   = rdata_q;
        case (state_q)
            S_IDLE: if (bus.start) begin
                is_in_d   = bus.is_in;
                addr_d    = bus.txn_addr;
                endp_d    = bus.txn_endp;
                wdata_d   = bus.wdata;
                retry_d   = RW'(1);
                success_d = 1'b0;
                rdata_d   = '0;
                state_d   = S_TOK;
            end
            S_TOK:  state_d = S_TOKW;
            S_TOKW: if (bus.tx_sent) begin
                tmo_d   = '0;
                state_d = is_in_q ? S_INW : S_DAT;
            end
            S_DAT:  state_d = S_DATW;
            S_DATW: if (bus.tx_sent) begin
                tmo_d   = '0;
                state_d = S_HSW;
            end
            // error beats NAK beats ACK; timeout only when nothing arrived
            S_HSW: begin
                tmo_d = tmo_q + TW'(1);
                if (bus.rx_error || bus.rx_nak) state_d = S_RETRY;
                else if (bus.rx_ack) begin
                    success_d = 1'b1;
                    state_d   = S_FIN;
                end else if (tmo_hit) state_d = S_RETRY;
            end
            S_INW: begin
                tmo_d = tmo_q + TW'(1);
                if (bus.rx_error || bus.rx_nak) state_d = S_RETRY;
                else if (bus.rx_pktready) begin
                    rdata_d = bus.rx_data;
                    state_d = S_ACK;
                end else if (tmo_hit) state_d = S_RETRY;
            end
            S_ACK:  state_d = S_ACKW;
            S_ACKW: if (bus.tx_sent) begin
                success_d = 1'b1;
                state_d   = S_FIN;
            end
            S_RETRY: if (retry_q == RW'(MAX_RETRY)) begin
                success_d = 1'b0;
                state_d   = S_FIN;
            end else begin
                retry_d = retry_q + RW'(1);
                state_d = S_TOK;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_FIN);
        pktready_d = (state_d == S_TOK) || (state_d == S_DAT) || (state_d == S_ACK);
        writing_d  = (state_d == S_TOK) || (state_d == S_TOKW) || (state_d == S_DAT) ||
                     (state_d == S_DATW) || (state_d == S_ACK) || (state_d == S_ACKW);
        pkttype_d  = (state_d == S_DAT);
        data_d     = (state_d == S_DAT) ? wdata_d : '0;
        pid_d      = '0;
        case (state_d)
            S_TOK:   pid_d = is_in_d ? PID_IN : PID_OUT;
            S_DAT:   pid_d = PID_DATA0;
            S_ACK:   pid_d = PID_ACK;
            default: pid_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst_L) begin
        if (rst_L) begin
            state_q    <= S_IDLE;
            retry_q    <= '0;
            tmo_q      <= '0;
            is_in_q    <= 1'b0;
            addr_q     <= '0;
            endp_q     <= '0;
            wdata_q    <= '0;
            success_q  <= 1'b0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pid_q      <= '0;
            data_q     <= '0;
            pkttype_q  <= 1'b0;
            pktready_q <= 1'b0;
            writing_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            retry_q    <= retry_d;
            tmo_q      <= tmo_d;
            is_in_q    <= is_in_d;
            addr_q     <= addr_d;
            endp_q     <= endp_d;
            wdata_q    <= wdata_d;
            success_q  <= success_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pid_q      <= pid_d;
            data_q     <= data_d;
            pkttype_q  <= pkttype_d;
            pktready_q <= pktready_d;
            writing_q  <= writing_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.success     = success_q;
    assign bus.rdata       = rdata_q;
    assign bus.pid         = pid_q;
    assign bus.addr        = addr_q;
    assign bus.endp        = endp_q;
    assign bus.data        = data_q;
    assign bus.pkttype     = pkttype_q;
    assign bus.pktready_bs = pktready_q;
    assign bus.writing     = writing_q;
endmodule

// File: doc/usb_txn_ctrl.md
Name: usb_txn_ctrl

Overview:
- Host-side USB transaction controller; sits directly upstream of the transmit pipeline (pipeOut) and downstream of the receive pipeline (pipeIn).
- Accepts one OUT or IN request from the host software model. Sequences token, data and handshake packets into pipeOut and consumes ACK/NAK/DATA results from pipeIn.
- Retries on NAK, error or timeout. Reports completion status and IN payload.

Parameters:
- TIMEOUT, 255, cycles to wait for a receive-side event before declaring timeout
- MAX_RETRY, 8, total attempts per transaction, first try included, before failing

Ports:
- clk  in  1  system clock
- rst_L  in  1  asynchronous reset, active-high (asserted = 1)
- start  in  1  1-cycle request pulse; ignored unless busy=0
- is_in  in  1  1 = IN transaction, 0 = OUT; sampled with start
- txn_addr  in  7  device address; sampled with start
- txn_endp  in  4  endpoint; sampled with start
- wdata  in  64  OUT payload; sampled with start
- busy  out  1  transaction in progress
- done  out  1  1-cycle completion pulse
- success  out  1  valid with done; 1 = ACKed OUT or clean IN
- rdata  out  64  IN payload; valid with done when success=1
- pid  out  4  packet PID to pipeOut
- addr  out  7  to pipeOut
- endp  out  4  to pipeOut
- data  out  64  to pipeOut
- pkttype  out  1  0 = token/handshake, 1 = data packet
- pktready_bs  out  1  1-cycle launch pulse to pipeOut
- tx_sent  in  1  1-cycle pulse: pipeOut finished emitting the current packet (EOP done)
- writing  out  1  bus direction to pipeIn; 1 while host drives the bus
- rx_pktready  in  1  pipeIn: data packet received, rx_data valid
- rx_data  in  64  pipeIn payload
- rx_error  in  1  pipeIn: CRC/PID/stuff error on received packet
- rx_ack  in  1  pipeIn: ACK received
- rx_nak  in  1  pipeIn: NAK received

Behaviour:
- PID encodings: OUT = 4'b0001, IN = 4'b1001, DATA0 = 4'b0011, ACK = 4'b0010.
- Reset values: all outputs 0, state IDLE, retry and timeout counters 0, request registers 0.
- start in IDLE latches is_in, txn_addr, txn_endp and wdata; busy=1 from the next cycle; retry count = 1.
- States and transitions:
  - IDLE: waits for start.
  - TOK: one cycle. pid = OUT or IN, pkttype=0, pktready_bs=1, writing=1. Next state TOKW.
  - TOKW: writing=1. On tx_sent, go to DAT if OUT, or INW if IN.
  - DAT: one cycle. pid = DATA0, pkttype=1, data = latched wdata, pktready_bs=1, writing=1. Next state DATW.
  - DATW: writing=1. On tx_sent, go to HSW.
  - HSW (OUT): writing=0, timeout counter runs.
    - rx_ack: go to FIN with success=1.
    - rx_nak, rx_error or timeout: go to RETRY.
  - INW (IN): writing=0, timeout counter runs.
    - rx_pktready with rx_error=0: capture rx_data into rdata, go to ACK.
    - rx_nak, rx_error or timeout: go to RETRY.
  - ACK: one cycle. pid = ACK, pkttype=0, pktready_bs=1, writing=1. Next state ACKW.
  - ACKW: on tx_sent, go to FIN with success=1.
  - RETRY: if retry count == MAX_RETRY, go to FIN with success=0. Otherwise increment retry count, go to TOK.
  - FIN: done=1 for one cycle, success holds the result. Next state IDLE with busy=0. success and rdata hold until the next start.
- addr and endp hold the latched request for the entire transaction.
- Timeout counter clears on entry to HSW or INW. Timeout fires when the count reaches TIMEOUT-1 with no event, i.e. exactly TIMEOUT cycles after entry.
- Simultaneous receive events in one cycle: rx_error wins over all others, then rx_nak, then rx_ack/rx_pktready.
- Receive events in non-wait states are ignored.
- tx_sent outside TOKW/DATW/ACKW is ignored.
- start while busy=1 is ignored; no queuing.
- Reset mid-transaction returns to IDLE immediately (asynchronous). No done pulse. pktready_bs and writing drop in the same cycle.
- Transaction latency, best case:
  - OUT = 3 + two tx durations + handshake wait + FIN.
  - No combinational path from rx_* or tx_sent to any output; all outputs are registered.

Test Plan:
- OUT to addr 7'h05 endp 4'h1, wdata 64'hDEADBEEF_01234567; bench ACKs 10 cycles after DATA tx_sent -> pid sequence OUT, DATA0; one done pulse with success=1; retry count 1.
- IN to addr 7'h12; bench returns rx_pktready with rx_data 64'hA5A5_0000_FFFF_1234 -> ACK packet launched; after its tx_sent, done=1, success=1, rdata = that value.
- OUT; bench NAKs twice, then ACKs -> three OUT tokens observed; success=1.
- IN with no response at all -> each wait lasts exactly 255 cycles; 8 tokens total; done with success=0.
- rx_error and rx_ack asserted in the same HSW cycle -> treated as error; token retransmitted.
- Reset asserted in DATW; start pulsed while busy -> controller returns to IDLE with all outputs 0 and no done pulse; the ignored start does not alter the latched addr.
